sig_period_meter: RTL and testbench
===================================

# sig_period_meter

Measures a slow asynchronous square wave against the master clock. Each rising edge yields the period and the high time, both counted in master-clock cycles, and a one-cycle valid strobe. It is the receiving end for the divided clocks the design generates (1 Hz, 2 Hz, 5 Hz, 500 Hz) and for external slow inputs, and is used for self-check and on-board display. If no edge arrives within a programmable window, the block raises a timeout flag and re-arms.

## Interface
- CNT_W, 27: width of cycle counters and measurement outputs.
- TIMEOUT, 100000000: cycles without a rising edge before timeout. Must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.
- clk  in  1  master clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- sig_in  in  1  measured signal; asynchronous to clk.
- period  out  CNT_W  cycles between the last two detected rising edges.
- high_time  out  CNT_W  cycles sig was high within that period.
- meas_valid  out  1  one-cycle strobe; period and high_time were updated this cycle.
- locked  out  1  high while in MEASURE (a reference edge is held).
- timeout  out  1  sticky; set on timeout, cleared on the next meas_valid.

## Operation
- Synchronizer: s1 ← sig_in, s2 ← s1, s3 ← s2. Rising-edge detect: rise = s2 & ~s3.
- Counters:
  - cnt (CNT_W): on rise, cnt ← 1; otherwise cnt ← cnt + 1 while in MEASURE.
  - hi (CNT_W): on rise, hi ← 1; otherwise hi ← hi + s2 while in MEASURE.
- State machine, states IDLE and MEASURE:
  - IDLE, no rise: hold; cnt and hi hold.
  - IDLE, rise: go to MEASURE, load cnt = 1 and hi = 1. No meas_valid.
  - MEASURE, rise: period ← cnt, high_time ← hi, meas_valid ← 1, timeout ← 0. Reload cnt = 1 and hi = 1. Stay in MEASURE.
  - MEASURE, no rise, cnt == TIMEOUT: go to IDLE, timeout ← 1. period and high_time keep their last values. No meas_valid.
  - MEASURE, otherwise: count.
- Width rule: cnt never exceeds TIMEOUT, so there is no wrap. high_time ≤ period always.
- locked = (state == MEASURE), registered with the state.

## Timing
- Reset values: period = 0, high_time = 0, meas_valid = 0, locked = 0, timeout = 0; state IDLE; s1 = s2 = s3 = 0; cnt = 0; hi = 0.
- Latency: if sig_in is first sampled high at clk edge k, rise is true between edges k+1 and k+2. Outputs update at edge k+2, so meas_valid is high for exactly the cycle after edge k+2.
- meas_valid is always exactly one cycle wide. Edges need at least 2 cycles between them after synchronization, so back-to-back strobes cannot occur.
- Simultaneous rise and cnt == TIMEOUT: the rise wins. A normal measurement is made with period = TIMEOUT and timeout is not set.
- Input high at reset release: s2 rises after release and is treated as a rising edge. It arms only; no measurement.
- Reset mid-measurement: all state clears immediately. The first edge after release arms only.
- Pulses shorter than one clk period may be missed. This is accepted; the input is slow by contract.
- Reported period = t1 − t0 in clk cycles, where t0 and t1 are consecutive rise cycles. high_time counts cycles where s2 = 1 in [t0, t1).

## Test plan
- Steady wave, TIMEOUT = 1000, sig_in period 100 clk, high 30 clk, 5 periods → 4 meas_valid strobes, each with period = 100, high_time = 30. locked = 1 from the first edge onward.
- Latency check: first sig_in rise sampled at edge k, second rise 100 cycles later → meas_valid high exactly in the cycle after edge k+102.
- Timeout: lock onto the wave, then hold sig_in low for 1200 cycles → timeout = 1 and locked = 0 exactly TIMEOUT cycles after the last rise. period and high_time keep 100 and 30. The next two rises produce one strobe and clear timeout.
- Boundary: rise exactly TIMEOUT cycles after the previous rise → meas_valid with period = 1000, timeout stays 0. At 1001 cycles → timeout, and no strobe on that edge.
- Reset: assert rst mid-period with sig_in high → all outputs 0 immediately. After release, one arming edge, then a correct measurement on the following edge.
- Real divider, defaults: feed the 500 Hz divided clock → period = 200000, high_time = 100000. Feed the 1 Hz divided clock → period = 100000000 = TIMEOUT, which is a valid measurement with no timeout.

Source files
------------

// File: rtl/sig_period_meter_if.sv
// Port bundle for the slow-signal period meter: measured input plus the
// measurement results and status flags it reports back.
interface sig_period_meter_if #(
    parameter int CNT_W = 27
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/sig_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with a sticky timeout when no rising edge arrives within TIMEOUT.
module sig_period_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    sig_period_meter_if.slave mif
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             rise_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    // Synchronizer, edge detect, measurement FSM and output next-state logic
    always_comb begin
        s1_d         = mif.sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        rise_s       = s2_q & ~s3_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                // First edge only arms the reference; nothing to report yet
                if (rise_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = ONE_C;
                    hi_d    = ONE_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A rise on the timeout cycle still counts as a valid period
                if (rise_s) begin
                    period_d     = cnt_q;
                    high_time_d  = hi_q;
                    meas_valid_d = 1'b1;
                    timeout_d    = 1'b0;
                    cnt_d        = ONE_C;
                    hi_d         = ONE_C;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                    hi_d  = hi_q + {{(CNT_W-1){1'b0}}, s2_q};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                hi_d    = {CNT_W{1'b0}};
            end
        endcase

        locked_d = (state_d == ST_MEASURE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            hi_q         <= {CNT_W{1'b0}};
            period_q     <= {CNT_W{1'b0}};
            high_time_q  <= {CNT_W{1'b0}};
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mif.period     = period_q;
    assign mif.high_time  = high_time_q;
    assign mif.meas_valid = meas_valid_q;
    assign mif.locked     = locked_q;
    assign mif.timeout    = timeout_q;

endmodule

// File: tb/tb_sig_period_meter.sv
// Directed bench for sig_period_meter: steady wave, latency, timeout and its
// boundary, reset mid-measurement, and a narrow-counter instance at full range.
module tb_sig_period_meter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sig_period_meter_if #(.CNT_W(27)) mif_a ();
    sig_period_meter_if #(.CNT_W(8))  mif_b ();

    sig_period_meter #(.CNT_W(27), .TIMEOUT(1000)) dut_a (
        .clk (clk),
        .rst (rst),
        .mif (mif_a)
    );

    sig_period_meter #(.CNT_W(8), .TIMEOUT(255)) dut_b (
        .clk (clk),
        .rst (rst),
        .mif (mif_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          strobe_cyc[$];
    int          bad_a     = 0;
    int          wide_a    = 0;
    int          strobes_b = 0;
    logic        prev_mv_a = 1'b0;
    logic [26:0] exp_p     = 27'd0;
    logic [26:0] exp_h     = 27'd0;

    int k, base, bad0;

    // Edge counter: after posedge number N, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge
    always @(negedge clk) begin
        if (mif_a.meas_valid === 1'b1) begin
            strobe_cyc.push_back(cyc);
            if (mif_a.period !== exp_p || mif_a.high_time !== exp_h) bad_a <= bad_a + 1;
        end
        if (mif_a.meas_valid === 1'b1 && prev_mv_a === 1'b1) wide_a <= wide_a + 1;
        prev_mv_a <= mif_a.meas_valid;
        if (mif_b.meas_valid === 1'b1) strobes_b <= strobes_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic pulse(input int h, input int l);
        mif_a.sig_in = 1'b1;
        tick(h);
        mif_a.sig_in = 1'b0;
        tick(l);
    endtask

    initial begin
        rst          = 1'b1;
        mif_a.sig_in = 1'b0;
        mif_b.sig_in = 1'b0;
        tick(4);
        check("rst_period",     {5'd0, mif_a.period},    32'd0);
        check("rst_high_time",  {5'd0, mif_a.high_time}, 32'd0);
        check("rst_meas_valid", {31'd0, mif_a.meas_valid}, 32'd0);
        check("rst_locked",     {31'd0, mif_a.locked},   32'd0);
        check("rst_timeout",    {31'd0, mif_a.timeout},  32'd0);
        rst = 1'b0;
        tick(3);

        // Steady wave: 100-cycle period, 30 high, five rises
        exp_p = 27'd100;
        exp_h = 27'd30;
        k     = cyc + 1;
        base  = strobe_cyc.size();
        bad0  = bad_a;
        for (int i = 0; i < 5; i++) begin
            mif_a.sig_in = 1'b1;
            tick(30);
            if (i == 0) check("locked_after_first_edge", {31'd0, mif_a.locked}, 32'd1);
            mif_a.sig_in = 1'b0;
            tick(70);
        end
        check("steady_strobes",    strobe_cyc.size() - base, 32'd4);
        check("steady_bad_values", bad_a - bad0,             32'd0);
        check("first_strobe_cyc",  strobe_cyc[base],         k + 102);
        check("steady_period",     {5'd0, mif_a.period},     32'd100);
        check("steady_high_time",  {5'd0, mif_a.high_time},  32'd30);
        check("steady_timeout",    {31'd0, mif_a.timeout},   32'd0);

        // Timeout: last rise sampled at k+400, flag lands at edge k+1402
        tick_to(k + 1401);
        check("pre_timeout_flag",   {31'd0, mif_a.timeout}, 32'd0);
        check("pre_timeout_locked", {31'd0, mif_a.locked},  32'd1);
        tick(1);
        check("timeout_flag",      {31'd0, mif_a.timeout},   32'd1);
        check("timeout_locked",    {31'd0, mif_a.locked},    32'd0);
        check("timeout_period",    {5'd0, mif_a.period},     32'd100);
        check("timeout_high_time", {5'd0, mif_a.high_time},  32'd30);
        tick_to(k + 499 + 1200);
        base = strobe_cyc.size();
        pulse(30, 70);
        check("rearm_no_strobe",     strobe_cyc.size() - base, 32'd0);
        check("rearm_timeout_holds", {31'd0, mif_a.timeout},   32'd1);
        check("rearm_locked",        {31'd0, mif_a.locked},    32'd1);
        pulse(300, 700);
        check("recover_strobes",   strobe_cyc.size() - base, 32'd1);
        check("recover_period",    {5'd0, mif_a.period},     32'd100);
        check("recover_high_time", {5'd0, mif_a.high_time},  32'd30);
        check("recover_timeout",   {31'd0, mif_a.timeout},   32'd0);

        // Boundary: 1000 cycles measures, 1001 cycles times out
        base = strobe_cyc.size();
        pulse(300, 701);
        check("bound_strobes",   strobe_cyc.size() - base, 32'd1);
        check("bound_period",    {5'd0, mif_a.period},     32'd1000);
        check("bound_high_time", {5'd0, mif_a.high_time},  32'd300);
        check("bound_timeout",   {31'd0, mif_a.timeout},   32'd0);
        pulse(30, 70);
        check("over_no_strobe", strobe_cyc.size() - base, 32'd1);
        check("over_timeout",   {31'd0, mif_a.timeout},   32'd1);
        check("over_period",    {5'd0, mif_a.period},     32'd1000);
        check("over_locked",    {31'd0, mif_a.locked},    32'd1);

        // Reset mid-period with the input high
        mif_a.sig_in = 1'b1;
        tick(10);
        rst = 1'b1;
        #1;
        check("midrst_period",    {5'd0, mif_a.period},      32'd0);
        check("midrst_high_time", {5'd0, mif_a.high_time},   32'd0);
        check("midrst_valid",     {31'd0, mif_a.meas_valid}, 32'd0);
        check("midrst_locked",    {31'd0, mif_a.locked},     32'd0);
        check("midrst_timeout",   {31'd0, mif_a.timeout},    32'd0);
        tick(3);
        rst  = 1'b0;
        base = strobe_cyc.size();
        tick(30);
        mif_a.sig_in = 1'b0;
        tick(70);
        check("postrst_arm_no_strobe", strobe_cyc.size() - base, 32'd0);
        check("postrst_locked",        {31'd0, mif_a.locked},    32'd1);
        check("postrst_period_zero",   {5'd0, mif_a.period},     32'd0);
        pulse(40, 60);
        check("postrst_strobes",   strobe_cyc.size() - base, 32'd1);
        check("postrst_period",    {5'd0, mif_a.period},     32'd100);
        check("postrst_high_time", {5'd0, mif_a.high_time},  32'd30);
        check("no_wide_strobes",   wide_a,                   32'd0);

        // Narrow instance: period equal to TIMEOUT = 2^8-1 is a valid measurement
        for (int i = 0; i < 3; i++) begin
            mif_b.sig_in = 1'b1;
            tick(128);
            mif_b.sig_in = 1'b0;
            tick(127);
        end
        mif_b.sig_in = 1'b1;
        tick(5);
        check("b_strobes",   strobes_b,                 32'd3);
        check("b_period",    {24'd0, mif_b.period},     32'd255);
        check("b_high_time", {24'd0, mif_b.high_time},  32'd128);
        check("b_timeout",   {31'd0, mif_b.timeout},    32'd0);
        check("b_locked",    {31'd0, mif_b.locked},     32'd1);
        mif_b.sig_in = 1'b0;
        tick(260);
        check("b_late_timeout", {31'd0, mif_b.timeout}, 32'd1);
        check("b_late_locked",  {31'd0, mif_b.locked},  32'd0);
        check("b_late_period",  {24'd0, mif_b.period},  32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
